ei_cmd_parser: RTL and testbench
================================

EI_CMD_PARSER -- requirements
Module: ei_cmd_parser

Interface
REQ-001 Parameter SOF_BYTE, 8'hA5, frame start marker.
REQ-002 Parameter MAX_LEN, 8, maximum data bytes per frame.
REQ-003 Parameter NUM_REGS, 47, register count; valid addresses are 0..46.
REQ-004 Parameter TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rx_data  in  8  received UART byte.
REQ-008 rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
REQ-009 reg_wr_en  out  1  register-memory write strobe.
REQ-010 reg_addr  out  6  write address (ei_regs_t index).
REQ-011 reg_wr_data  out  8  write data.
REQ-012 ack  out  1  one-cycle pulse: frame fully committed.
REQ-013 err  out  1  one-cycle pulse: frame or byte rejected.
REQ-014 err_code  out  3  cause, valid with err: 1 bad address, 2 bad length, 3 checksum, 4 timeout, 5 overrun.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, ADDR, LEN, DATA, CHK and COMMIT.
REQ-017 IDLE: a byte equal to SOF_BYTE -> ADDR; any other byte is silently dropped.
REQ-018 ADDR: latch the byte as the start address and load it into a running XOR checksum -> LEN.
REQ-019 LEN: LEN == 0 or LEN > MAX_LEN -> err, code 2, -> IDLE.
REQ-020 LEN: address > 46 or address + LEN - 1 > 46 (8-bit compare, no wrap) -> err, code 1, -> IDLE.
REQ-021 LEN: if both checks pass, XOR the byte into the checksum -> DATA.
REQ-022 DATA: store each byte in an internal MAX_LEN x 8 buffer and XOR it into the checksum; after LEN bytes -> CHK.
REQ-023 CHK: a byte equal to the checksum -> COMMIT; otherwise err, code 3, -> IDLE, with zero writes issued.
REQ-024 COMMIT: starts the cycle after the CHK byte; issues one write per cycle for LEN consecutive cycles.
REQ-025 COMMIT: reg_addr = start address + i and reg_wr_data = buffer[i], for i = 0..LEN-1.
REQ-026 ack SHALL pulse the cycle after the last write; the FSM returns to IDLE in that same cycle.
REQ-027 Frame latency: CHK byte accepted at cycle T -> writes at T+1..T+LEN -> ack at T+LEN+1.
REQ-028 rx_valid during COMMIT: the byte is dropped and err pulses with code 5 that cycle; the commit continues unaffected.
REQ-029 A timeout counter SHALL clear on every accepted byte and count while in ADDR, LEN, DATA or CHK.
REQ-030 When the count reaches TIMEOUT_CYCLES: err, code 4, -> IDLE, buffer discarded.
REQ-031 err and ack are mutually exclusive except where REQ-028 overlaps ack; in that case both pulse.
REQ-032 reg_wr_en SHALL be high only in COMMIT; reg_addr and reg_wr_data are don't-care when it is low.
REQ-033 A SOF_BYTE value received in ADDR, LEN, DATA or CHK is treated as ordinary data; there is no resynchronisation.

Reset
REQ-034 On rst: state IDLE; reg_wr_en, ack, err, busy = 0; err_code, reg_addr, reg_wr_data = 0; checksum, counters and timeout counter cleared.
REQ-035 rst asserted mid-frame or mid-commit SHALL abort the frame immediately, with no further writes and no ack or err pulse.

Verification
REQ-036 Good frame: A5 10 02 AA BB 03 -> writes (16, AA), (17, BB) on consecutive cycles, then ack; err stays 0.
REQ-037 Bad checksum: A5 10 02 AA BB 04 -> err, code 3, one cycle after the 04 byte; no reg_wr_en.
REQ-038 Range and length: A5 2D 03 -> err code 1 after LEN; A5 05 00 -> err code 2; A5 05 09 -> err code 2.
REQ-039 Timeout: A5 10, then silence for TIMEOUT_CYCLES -> err code 4; a following good frame is then accepted normally.
REQ-040 Overrun: a byte injected in the second commit cycle of an 8-byte frame -> err code 5; all 8 writes complete, then ack.
REQ-041 Reset: rst asserted during the DATA state, then a good frame -> no writes from the aborted frame; the new frame commits correctly.

Source files
------------

// File: rtl/ei_cmd_parser_if.sv
// Byte-stream in, register-write strobes and status pulses out, for the
// framed command parser. Two views: the frame source/observer side
// (master) and the parser side (slave).
interface ei_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       reg_wr_en;
  logic [5:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       ack;
  logic       err;
  logic [2:0] err_code;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    input  reg_wr_en,
    input  reg_addr,
    input  reg_wr_data,
    input  ack,
    input  err,
    input  err_code,
    input  busy
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output reg_wr_en,
    output reg_addr,
    output reg_wr_data,
    output ack,
    output err,
    output err_code,
    output busy
  );
endinterface

// File: rtl/ei_cmd_parser.sv
// Framed UART command parser.
// Frame: SOF, start address, length, length data bytes, XOR checksum.
// The checksum covers address, length and data. A frame that passes every
// check is written into the register file one byte per cycle starting the
// cycle after the checksum byte, followed by a one-cycle ack. Rejected
// frames produce a one-cycle err with a cause code and no writes.
module ei_cmd_parser #(
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         MAX_LEN        = 8,
  parameter int         NUM_REGS       = 47,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input logic            clk,
  input logic            rst,
  ei_cmd_parser_if.slave bus
);

  // Length/count width holds 0..MAX_LEN; buffer index width holds 0..MAX_LEN-1.
  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);
  localparam logic [8:0]    NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [8:0]    LAST_REG_W = 9'(NUM_REGS - 1);
  localparam logic [IW-1:0] ONE_IW     = IW'(1);
  localparam logic [TW-1:0] ONE_TW     = TW'(1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ERR_ADDR     = 3'd1;
  localparam logic [2:0] ERR_LEN      = 3'd2;
  localparam logic [2:0] ERR_CHECKSUM = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_OVERRUN  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    LEN    = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    COMMIT = 3'd5
  } state_t;

  // Running frame checksum: plain XOR of every byte after SOF.
  function automatic logic [7:0] chk_upd(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t        state_r;
  logic [7:0]    start_addr_r;
  logic [IW-1:0] len_r;
  logic [IW-1:0] cnt_r;
  logic [7:0]    chk_r;
  logic [TW-1:0] to_cnt_r;
  logic [7:0]    buf_r [MAX_LEN];

  logic          reg_wr_en_r;
  logic [5:0]    reg_addr_r;
  logic [7:0]    reg_wr_data_r;
  logic          ack_r;
  logic          err_r;
  logic [2:0]    err_code_r;
  logic          busy_r;

  logic          len_bad_s;
  logic          addr_bad_s;
  logic          chk_ok_s;

  // Frame validity checks on the byte currently presented (length byte / checksum byte).
  always_comb begin
    len_bad_s  = 1'b0;
    addr_bad_s = 1'b0;
    chk_ok_s   = 1'b0;
    if ((bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN_B)) begin
      len_bad_s = 1'b1;
    end else begin
      len_bad_s = 1'b0;
    end
    // 9-bit sums so a large address plus length cannot wrap past the check.
    if (({1'b0, start_addr_r} > LAST_REG_W) ||
        (({1'b0, start_addr_r} + {1'b0, bus.rx_data}) > NUM_REGS_W)) begin
      addr_bad_s = 1'b1;
    end else begin
      addr_bad_s = 1'b0;
    end
    if (bus.rx_data == chk_r) begin
      chk_ok_s = 1'b1;
    end else begin
      chk_ok_s = 1'b0;
    end
  end

  // Frame FSM: byte collection, checks, timeout, commit sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      start_addr_r  <= 8'd0;
      len_r         <= '0;
      cnt_r         <= '0;
      chk_r         <= 8'd0;
      to_cnt_r      <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_r[i] <= 8'd0;
      end
      reg_wr_en_r   <= 1'b0;
      reg_addr_r    <= 6'd0;
      reg_wr_data_r <= 8'd0;
      ack_r         <= 1'b0;
      err_r         <= 1'b0;
      err_code_r    <= 3'd0;
      busy_r        <= 1'b0;
    end else begin
      // Status strobes are single-cycle unless re-raised below.
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= 3'd0;

      case (state_r)
        IDLE: begin
          reg_wr_en_r <= 1'b0;
          to_cnt_r    <= '0;
          cnt_r       <= '0;
          if (bus.rx_valid && (bus.rx_data == SOF_BYTE)) begin
            state_r <= ADDR;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end

        ADDR, LEN, DATA, CHK: begin
          reg_wr_en_r <= 1'b0;
          if (!bus.rx_valid) begin
            // Silence on the line: give up on the frame after TIMEOUT_CYCLES.
            if (to_cnt_r == TO_LAST) begin
              to_cnt_r   <= '0;
              cnt_r      <= '0;
              err_r      <= 1'b1;
              err_code_r <= ERR_TIMEOUT;
              state_r    <= IDLE;
              busy_r     <= 1'b0;
            end else begin
              to_cnt_r <= to_cnt_r + ONE_TW;
            end
          end else begin
            to_cnt_r <= '0;
            case (state_r)
              ADDR: begin
                start_addr_r <= bus.rx_data;
                chk_r        <= bus.rx_data;
                state_r      <= LEN;
              end
              LEN: begin
                if (len_bad_s) begin
                  err_r      <= 1'b1;
                  err_code_r <= ERR_LEN;
                  state_r    <= IDLE;
                  busy_r     <= 1'b0;
                end else if (addr_bad_s) begin
                  err_r      <= 1'b1;
                  err_code_r <= ERR_ADDR;
                  state_r    <= IDLE;
                  busy_r     <= 1'b0;
                end else begin
                  len_r   <= bus.rx_data[IW-1:0];
                  chk_r   <= chk_upd(chk_r, bus.rx_data);
                  cnt_r   <= '0;
                  state_r <= DATA;
                end
              end
              DATA: begin
                buf_r[cnt_r[AW-1:0]] <= bus.rx_data;
                chk_r                <= chk_upd(chk_r, bus.rx_data);
                if ((cnt_r + ONE_IW) == len_r) begin
                  cnt_r   <= '0;
                  state_r <= CHK;
                end else begin
                  cnt_r   <= cnt_r + ONE_IW;
                end
              end
              CHK: begin
                if (chk_ok_s) begin
                  // First write goes out in the cycle right after the checksum byte.
                  reg_wr_en_r   <= 1'b1;
                  reg_addr_r    <= start_addr_r[5:0];
                  reg_wr_data_r <= buf_r[{AW{1'b0}}];
                  cnt_r         <= ONE_IW;
                  state_r       <= COMMIT;
                end else begin
                  err_r      <= 1'b1;
                  err_code_r <= ERR_CHECKSUM;
                  state_r    <= IDLE;
                  busy_r     <= 1'b0;
                end
              end
              default: begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            endcase
          end
        end

        COMMIT: begin
          to_cnt_r <= '0;
          // Bytes arriving mid-commit are dropped and flagged; the commit itself runs on.
          if (bus.rx_valid) begin
            err_r      <= 1'b1;
            err_code_r <= ERR_OVERRUN;
          end else begin
            err_r      <= 1'b0;
          end
          if (cnt_r == len_r) begin
            reg_wr_en_r <= 1'b0;
            ack_r       <= 1'b1;
            cnt_r       <= '0;
            state_r     <= IDLE;
            busy_r      <= 1'b0;
          end else begin
            reg_wr_en_r   <= 1'b1;
            reg_addr_r    <= reg_addr_r + 6'd1;
            reg_wr_data_r <= buf_r[cnt_r[AW-1:0]];
            cnt_r         <= cnt_r + ONE_IW;
          end
        end

        default: begin
          state_r     <= IDLE;
          reg_wr_en_r <= 1'b0;
          cnt_r       <= '0;
          to_cnt_r    <= '0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_wr_en   = reg_wr_en_r;
  assign bus.reg_addr    = reg_addr_r;
  assign bus.reg_wr_data = reg_wr_data_r;
  assign bus.ack         = ack_r;
  assign bus.err         = err_r;
  assign bus.err_code    = err_code_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_ei_cmd_parser.sv
// Directed bench for ei_cmd_parser: hand-computed frames, a negedge monitor
// logging writes/ack/err with cycle stamps, and one checking task.
module tb_ei_cmd_parser;

  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst;

  ei_cmd_parser_if bus_if ();

  ei_cmd_parser #(
    .SOF_BYTE      (8'hA5),
    .MAX_LEN       (8),
    .NUM_REGS      (47),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  // Cycle stamp: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int ack_cnt, ack_cyc, err_cnt, err_cyc, err_code_last;
  int last_cyc;

  // Monitor: log every write, ack and err with the edge that produced it.
  always @(negedge clk) begin
    if (bus_if.reg_wr_en) begin
      wr_addr_q.push_back(int'(bus_if.reg_addr));
      wr_data_q.push_back(int'(bus_if.reg_wr_data));
      wr_cyc_q.push_back(cyc);
    end
    if (bus_if.ack) begin
      ack_cnt++;
      ack_cyc = cyc;
    end
    if (bus_if.err) begin
      err_cnt++;
      err_cyc = cyc;
      err_code_last = int'(bus_if.err_code);
    end
  end

  task automatic check_val(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clr_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    ack_cnt = 0; ack_cyc = -1;
    err_cnt = 0; err_cyc = -1; err_code_last = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A frame that must be rejected on its last byte with the given code.
  task automatic err_case(input string tag, input logic [7:0] q[$], input int code);
    int t;
    clr_log();
    send_seq(q);
    t = last_cyc;
    wait_cyc(4);
    check_val({tag, "_err_cnt"}, err_cnt, 1);
    check_val({tag, "_code"}, err_code_last, code);
    check_val({tag, "_err_lat"}, err_cyc, t);
    check_val({tag, "_no_wr"}, wr_addr_q.size(), 0);
    check_val({tag, "_no_ack"}, ack_cnt, 0);
    check_val({tag, "_busy"}, int'(bus_if.busy), 0);
  endtask

  logic [7:0] seq[$];
  int t;

  initial begin
    rst = 1'b1;
    bus_if.rx_data  = 8'h00;
    bus_if.rx_valid = 1'b0;
    clr_log();
    wait_cyc(3);
    check_val("rst_busy", int'(bus_if.busy), 0);
    check_val("rst_wr_en", int'(bus_if.reg_wr_en), 0);
    check_val("rst_ack", int'(bus_if.ack), 0);
    check_val("rst_err", int'(bus_if.err), 0);
    check_val("rst_err_code", int'(bus_if.err_code), 0);
    check_val("rst_addr", int'(bus_if.reg_addr), 0);
    rst = 1'b0;
    wait_cyc(2);

    // Good frame: A5 10 02 AA BB 03 -> (16,AA),(17,BB), then ack.
    clr_log();
    send_byte(8'h42);  // noise in IDLE is dropped
    send_byte(8'hA5);
    check_val("good_busy_sof", int'(bus_if.busy), 1);
    seq = '{8'h10, 8'h02, 8'hAA, 8'hBB, 8'h03};
    send_seq(seq);
    t = last_cyc;
    wait_cyc(6);
    check_val("good_wr_cnt", wr_addr_q.size(), 2);
    check_val("good_addr0", q_at(wr_addr_q, 0), 16);
    check_val("good_data0", q_at(wr_data_q, 0), 8'hAA);
    check_val("good_addr1", q_at(wr_addr_q, 1), 17);
    check_val("good_data1", q_at(wr_data_q, 1), 8'hBB);
    check_val("good_wr0_cyc", q_at(wr_cyc_q, 0), t);
    check_val("good_wr1_cyc", q_at(wr_cyc_q, 1), t + 1);
    check_val("good_ack_cnt", ack_cnt, 1);
    check_val("good_ack_cyc", ack_cyc, t + 2);
    check_val("good_err_cnt", err_cnt, 0);
    check_val("good_busy_end", int'(bus_if.busy), 0);

    // Rejections.
    err_case("bad_chk", '{8'hA5, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'h04}, 3);
    err_case("range_2d_3", '{8'hA5, 8'h2D, 8'h03}, 1);
    err_case("range_2f_1", '{8'hA5, 8'h2F, 8'h01}, 1);
    err_case("len_zero", '{8'hA5, 8'h05, 8'h00}, 2);
    err_case("len_nine", '{8'hA5, 8'h05, 8'h09}, 2);

    // Top-of-range frame: registers 45 and 46; checksum 2D^02^01^02 = 2C.
    clr_log();
    seq = '{8'hA5, 8'h2D, 8'h02, 8'h01, 8'h02, 8'h2C};
    send_seq(seq);
    wait_cyc(5);
    check_val("edge_wr_cnt", wr_addr_q.size(), 2);
    check_val("edge_addr1", q_at(wr_addr_q, 1), 46);
    check_val("edge_data1", q_at(wr_data_q, 1), 8'h02);
    check_val("edge_ack", ack_cnt, 1);

    // SOF value inside a frame is data: A5 03 01 A5 A7 -> (3,A5).
    clr_log();
    seq = '{8'hA5, 8'h03, 8'h01, 8'hA5, 8'hA7};
    send_seq(seq);
    wait_cyc(5);
    check_val("sofdata_wr_cnt", wr_addr_q.size(), 1);
    check_val("sofdata_addr", q_at(wr_addr_q, 0), 3);
    check_val("sofdata_data", q_at(wr_data_q, 0), 8'hA5);
    check_val("sofdata_err", err_cnt, 0);

    // Timeout after A5 10, then a good frame is accepted.
    clr_log();
    seq = '{8'hA5, 8'h10};
    send_seq(seq);
    t = last_cyc;
    wait_cyc(TO - 20);
    check_val("to_early", err_cnt, 0);
    wait_cyc(40);
    check_val("to_err_cnt", err_cnt, 1);
    check_val("to_code", err_code_last, 4);
    check_val("to_cyc", err_cyc, t + TO);
    check_val("to_busy", int'(bus_if.busy), 0);
    clr_log();
    seq = '{8'hA5, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'h03};
    send_seq(seq);
    wait_cyc(5);
    check_val("to_after_wr_cnt", wr_addr_q.size(), 2);
    check_val("to_after_ack", ack_cnt, 1);

    // Overrun: 8-byte frame at 0, data 11..88, checksum 80; byte in 2nd commit cycle.
    clr_log();
    seq = '{8'hA5, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h80};
    send_seq(seq);
    t = last_cyc;
    @(negedge clk);
    bus_if.rx_data  = 8'h5A;
    bus_if.rx_valid = 1'b1;
    @(negedge clk);
    bus_if.rx_valid = 1'b0;
    wait_cyc(12);
    check_val("ovr_wr_cnt", wr_addr_q.size(), 8);
    check_val("ovr_addr0", q_at(wr_addr_q, 0), 0);
    check_val("ovr_data0", q_at(wr_data_q, 0), 8'h11);
    check_val("ovr_addr7", q_at(wr_addr_q, 7), 7);
    check_val("ovr_data7", q_at(wr_data_q, 7), 8'h88);
    check_val("ovr_wr7_cyc", q_at(wr_cyc_q, 7), t + 7);
    check_val("ovr_err_cnt", err_cnt, 1);
    check_val("ovr_code", err_code_last, 5);
    check_val("ovr_err_cyc", err_cyc, t + 2);
    check_val("ovr_ack_cnt", ack_cnt, 1);
    check_val("ovr_ack_cyc", ack_cyc, t + 8);

    // Reset during DATA, then a fresh frame: A5 20 01 5A 7B -> (32,5A).
    clr_log();
    seq = '{8'hA5, 8'h10, 8'h02, 8'hAA};
    send_seq(seq);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rstmid_busy", int'(bus_if.busy), 0);
    wait_cyc(10);
    check_val("rstmid_no_wr", wr_addr_q.size(), 0);
    check_val("rstmid_no_ack", ack_cnt, 0);
    check_val("rstmid_no_err", err_cnt, 0);
    seq = '{8'hA5, 8'h20, 8'h01, 8'h5A, 8'h7B};
    send_seq(seq);
    wait_cyc(5);
    check_val("rstmid_wr_cnt", wr_addr_q.size(), 1);
    check_val("rstmid_addr", q_at(wr_addr_q, 0), 32);
    check_val("rstmid_data", q_at(wr_data_q, 0), 8'h5A);
    check_val("rstmid_ack", ack_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
